alu_rs_param: RTL

Parametrised ALU reservation station holding RS_DEPTH pending ALU ops between decode/ROB allocation and one pipelined ALU issue port. Operands are captured from the allocating source or from any of NUM_CDB common-data-bus channels; wakeup is tag-based. Selection is oldest-ready-first via an age matrix, with a valid/ready issue handshake and a synchronous flush on mispredict. It replaces the fixed 4-entry, first-free, one-ALU-per-entry station.

---
 rtl/alu_rs_param_if.sv | 47 ++++
 rtl/alu_rs_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_param_if.sv
// Decode/CDB/issue bundle of the ALU reservation station. The slave modport is the
// station; the master modport is the surrounding pipeline (decoder, CDB, ALU).
interface alu_rs_param_if #(
    parameter int RS_DEPTH = 8,
    parameter int NUM_CDB  = 4,
    parameter int TAG_W    = 3,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 3
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    logic                      flush;
    logic                      alloc_valid;
    logic                      alloc_ready;
    logic [OP_W-1:0]           alloc_op;
    logic [TAG_W-1:0]          alloc_rob_tag;
    logic                      alloc_src1_rdy;
    logic                      alloc_src2_rdy;
    logic [DATA_W-1:0]         alloc_src1_val;
    logic [DATA_W-1:0]         alloc_src2_val;
    logic [TAG_W-1:0]          alloc_src1_tag;
    logic [TAG_W-1:0]          alloc_src2_tag;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_value;
    logic                      issue_valid;
    logic                      issue_ready;
    logic [OP_W-1:0]           issue_op;
    logic [DATA_W-1:0]         issue_a;
    logic [DATA_W-1:0]         issue_b;
    logic [TAG_W-1:0]          issue_rob_tag;
    logic [CNT_W-1:0]          free_count;

    modport slave (
        input  flush, alloc_valid, alloc_op, alloc_rob_tag,
               alloc_src1_rdy, alloc_src2_rdy, alloc_src1_val, alloc_src2_val,
               alloc_src1_tag, alloc_src2_tag, cdb_valid, cdb_tag, cdb_value, issue_ready,
        output alloc_ready, issue_valid, issue_op, issue_a, issue_b, issue_rob_tag, free_count
    );

    modport master (
        output flush, alloc_valid, alloc_op, alloc_rob_tag,
               alloc_src1_rdy, alloc_src2_rdy, alloc_src1_val, alloc_src2_val,
               alloc_src1_tag, alloc_src2_tag, cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  alloc_ready, issue_valid, issue_op, issue_a, issue_b, issue_rob_tag, free_count
    );
endinterface

// File: rtl/alu_rs_param.sv
// ALU reservation station: RS_DEPTH entries, tag-based CDB wakeup, oldest-ready-first
// select through an age matrix, one valid/ready issue port and a synchronous flush.

// One source operand snooping all CDB channels; the lowest matching channel wins.
module alu_rs_param_cdb_match #(
    parameter int NUM_CDB = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic [TAG_W-1:0]          src_tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic                      hit,
    output logic [DATA_W-1:0]         val
);
    always_comb begin
        hit = 1'b0;
        val = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == src_tag) begin
                hit = 1'b1;
                val = cdb_value[k*DATA_W +: DATA_W];
            end
        end
    end
endmodule

module alu_rs_param #(
    parameter int RS_DEPTH = 8,
    parameter int NUM_CDB  = 4,
    parameter int TAG_W    = 3,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_rs_param_if.slave io
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } src_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] rob_tag;
        src_t             s1;
        src_t             s2;
    } ent_t;

    logic [RS_DEPTH-1:0]               busy_q, busy_d;
    ent_t                              ent_q [RS_DEPTH];
    ent_t                              ent_d [RS_DEPTH];
    // older_q[i][j] = 1 means entry j was allocated before entry i
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;

    logic [RS_DEPTH-1:0]             ready, sel, iss_oh;
    logic [RS_DEPTH-1:0]             wk1_hit, wk2_hit;
    logic [RS_DEPTH-1:0][DATA_W-1:0] wk1_val, wk2_val;
    logic                            by1_hit, by2_hit;
    logic [DATA_W-1:0]               by1_val, by2_val;
    logic                            fire, alloc_fire;
    logic [IDX_W-1:0]                alloc_idx;
    logic [CNT_W-1:0]                free_cnt;
    ent_t                            new_ent;

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_wake
        alu_rs_param_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_wk1 (
            .src_tag(ent_q[i].s1.tag), .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag),
            .cdb_value(io.cdb_value), .hit(wk1_hit[i]), .val(wk1_val[i]));
        alu_rs_param_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_wk2 (
            .src_tag(ent_q[i].s2.tag), .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag),
            .cdb_value(io.cdb_value), .hit(wk2_hit[i]), .val(wk2_val[i]));
    end

    alu_rs_param_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_by1 (
        .src_tag(io.alloc_src1_tag), .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag),
        .cdb_value(io.cdb_value), .hit(by1_hit), .val(by1_val));
    alu_rs_param_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_by2 (
        .src_tag(io.alloc_src2_tag), .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag),
        .cdb_value(io.cdb_value), .hit(by2_hit), .val(by2_val));

    // Select and free accounting look only at registered state: no CDB-to-issue path.
    always_comb begin
        free_cnt  = '0;
        alloc_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready[i] = busy_q[i] & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
            free_cnt = free_cnt + CNT_W'(!busy_q[i]);
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!busy_q[i]) alloc_idx = IDX_W'(i);
        for (int i = 0; i < RS_DEPTH; i++)
            sel[i] = ready[i] & ~|(older_q[i] & ready);
    end

    assign fire       = io.issue_valid & io.issue_ready;
    assign iss_oh     = sel & {RS_DEPTH{fire}};
    assign alloc_fire = io.alloc_valid & io.alloc_ready;

    always_comb begin
        io.issue_valid   = |ready;
        io.issue_op      = '0;
        io.issue_a       = '0;
        io.issue_b       = '0;
        io.issue_rob_tag = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (sel[i]) begin
                io.issue_op      = io.issue_op | ent_q[i].op;
                io.issue_a       = io.issue_a | ent_q[i].s1.val;
                io.issue_b       = io.issue_b | ent_q[i].s2.val;
                io.issue_rob_tag = io.issue_rob_tag | ent_q[i].rob_tag;
            end
        end
    end

    assign io.alloc_ready = (free_cnt != '0);
    assign io.free_count  = free_cnt;

    always_comb begin
        new_ent.op      = io.alloc_op;
        new_ent.rob_tag = io.alloc_rob_tag;
        new_ent.s1.tag  = io.alloc_src1_tag;
        new_ent.s2.tag  = io.alloc_src2_tag;
        new_ent.s1.rdy  = io.alloc_src1_rdy | by1_hit;
        new_ent.s2.rdy  = io.alloc_src2_rdy | by2_hit;
        new_ent.s1.val  = io.alloc_src1_rdy ? io.alloc_src1_val : by1_val;
        new_ent.s2.val  = io.alloc_src2_rdy ? io.alloc_src2_val : by2_val;
    end

    always_comb begin
        busy_d  = busy_q;
        older_d = older_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (busy_q[i] && !ent_q[i].s1.rdy && wk1_hit[i]) begin
                ent_d[i].s1.rdy = 1'b1;
                ent_d[i].s1.val = wk1_val[i];
            end
            if (busy_q[i] && !ent_q[i].s2.rdy && wk2_hit[i]) begin
                ent_d[i].s2.rdy = 1'b1;
                ent_d[i].s2.val = wk2_val[i];
            end
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (iss_oh[i]) begin
                busy_d[i] = 1'b0;
                for (int r = 0; r < RS_DEPTH; r++) older_d[r][i] = 1'b0;
            end
        end
        // New entry is younger than everything still resident after this cycle's issue.
        if (alloc_fire) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (IDX_W'(i) == alloc_idx) begin
                    busy_d[i]  = 1'b1;
                    ent_d[i]   = new_ent;
                    older_d[i] = busy_q & ~iss_oh;
                    for (int r = 0; r < RS_DEPTH; r++) older_d[r][i] = 1'b0;
                end
            end
        end
        if (io.flush) begin
            busy_d  = '0;
            older_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            older_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
        end else begin
            busy_q  <= busy_d;
            older_q <= older_d;
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end
endmodule
